// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: command-driven initiator for reg_file.
// Accepts WRITE / READ-pair / CLEAR commands over a valid-ready channel and
// drives the reg_file pins.  Read-pair data comes back on a valid-ready
// response channel.
// Optional feature macro: RFC_READBACK_EN.  When defined, every WRITE is
// followed by a one-cycle VERIFY that reads the register back and sets a
// sticky err on mismatch.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a command; captures fields on accept
// WRITE  | single rf_wr pulse with captured address/data
// VERIFY | (RFC_READBACK_EN) read back written register, compare to data
// READ   | drive read addresses; register d_out_a/b at closing edge
// RESP   | hold response until consumer accepts
// CLEAR  | DEPTH consecutive writes of CLEAR_VAL, address 0..DEPTH-1
module reg_file_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 3,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_wr_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic              busy,
  output logic              err,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_rd_addr_a,
  output logic [ADDR_W-1:0] rf_rd_addr_b,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_d_in,
  input  logic [DATA_W-1:0] rf_d_out_a,
  input  logic [DATA_W-1:0] rf_d_out_b
);

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Depth is a power of two, so the last address is all ones.
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_READ   = 3'd2,
    S_RESP   = 3'd3,
    S_CLEAR  = 3'd4,
    S_VERIFY = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;

  // Handshake/status outputs decode straight from state so that an async
  // reset drops rf_wr without waiting for a clock edge.
  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign rf_wr     = (state == S_WRITE) || (state == S_CLEAR);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE: state_nxt = S_WRITE;
            OP_READ:  state_nxt = S_READ;
            OP_CLEAR: state_nxt = S_CLEAR;
            default:  state_nxt = S_IDLE;
          endcase
        end
      end
`ifdef RFC_READBACK_EN
      S_WRITE:  state_nxt = S_VERIFY;
      S_VERIFY: state_nxt = S_IDLE;
`else
      S_WRITE:  state_nxt = S_IDLE;
`endif
      S_READ:   state_nxt = S_RESP;
      S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
      S_CLEAR:  if (clr_cnt == LAST_ADDR) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Pin/capture registers: rf pins double as the captured command fields and
  // keep their last driven value whenever they are not in use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_rd_addr_a <= '0;
      rf_rd_addr_b <= '0;
      rf_wr_addr   <= '0;
      rf_d_in      <= '0;
      rsp_data_a   <= '0;
      rsp_data_b   <= '0;
      clr_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_WRITE: begin
                rf_wr_addr <= cmd_wr_addr;
                rf_d_in    <= cmd_data;
              end
              OP_READ: begin
                rf_rd_addr_a <= cmd_addr_a;
                rf_rd_addr_b <= cmd_addr_b;
              end
              OP_CLEAR: begin
                rf_wr_addr <= '0;
                rf_d_in    <= CLEAR_VAL;
                clr_cnt    <= '0;
              end
              default: ;
            endcase
          end
        end
`ifdef RFC_READBACK_EN
        S_WRITE: rf_rd_addr_a <= rf_wr_addr;
`endif
        S_READ: begin
          rsp_data_a <= rf_d_out_a;
          rsp_data_b <= rf_d_out_b;
        end
        S_CLEAR: begin
          // Counter wraps; the address pin stops at the last address.
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt != LAST_ADDR) rf_wr_addr <= clr_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RFC_READBACK_EN
  logic err_q;

  // Sticky readback mismatch; rf_d_in still holds the written data in VERIFY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                         err_q <= 1'b0;
    else if (state == S_VERIFY && rf_d_out_a != rf_d_in) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Testbench for reg_file_ctrl with a behavioural reg_file attached and a
// command-level reference model of the register contents.
module tb_reg_file_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr_a, cmd_addr_b, cmd_wr_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data_a, rsp_data_b;
  logic          busy, err, rf_wr;
  logic [AW-1:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic [DW-1:0] rf_d_in, rf_d_out_a, rf_d_out_b;

  logic [DW-1:0] rf_mem  [8];
  logic [DW-1:0] ref_mem [8];
  logic          corrupt = 1'b0;
  int            wr_pulses = 0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  reg_file_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_VAL(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
    .cmd_wr_addr(cmd_wr_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .busy(busy), .err(err), .rf_wr(rf_wr),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in),
    .rf_d_out_a(rf_d_out_a), .rf_d_out_b(rf_d_out_b)
  );

  // Behavioural reg_file: synchronous write, combinational read.
  always @(posedge clk) begin
    if (rf_wr === 1'b1) begin
      rf_mem[rf_wr_addr] <= rf_d_in;
      wr_pulses <= wr_pulses + 1;
    end
  end
  assign rf_d_out_a = rf_mem[rf_rd_addr_a] ^ (corrupt ? 16'h0001 : 16'h0000);
  assign rf_d_out_b = rf_mem[rf_rd_addr_b];

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [AW-1:0] wa, input logic [DW-1:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 30) begin tick(); n++; end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr_a = a; cmd_addr_b = b;
    cmd_wr_addr = wa; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] wa, input logic [DW-1:0] d);
    int p0;
    send(2'b01, 3'd0, 3'd0, wa, d);
    p0 = wr_pulses;
    chk("wr_rf_wr", rf_wr, 1);
    chk("wr_addr", rf_wr_addr, wa);
    chk("wr_d_in", rf_d_in, d);
    chk("wr_busy", busy, 1);
    chk("wr_cmd_ready", cmd_ready, 0);
    tick();
`ifdef RFC_READBACK_EN
    chk("vfy_rf_wr", rf_wr, 0);
    chk("vfy_busy", busy, 1);
    chk("vfy_rd_addr", rf_rd_addr_a, wa);
    tick();
`endif
    chk("wr_done_rf_wr", rf_wr, 0);
    chk("wr_done_busy", busy, 0);
    chk("wr_pulse_count", wr_pulses - p0, 1);
    ref_mem[wa] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b, input int hold);
    int p0;
    send(2'b10, a, b, 3'd0, 16'h0000);
    p0 = wr_pulses;
    chk("rd_valid_early", rsp_valid, 0);
    chk("rd_busy", busy, 1);
    chk("rd_addr_a", rf_rd_addr_a, a);
    chk("rd_addr_b", rf_rd_addr_b, b);
    tick();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data_a", rsp_data_a, ref_mem[a]);
    chk("rsp_data_b", rsp_data_b, ref_mem[b]);
    for (int i = 0; i < hold; i++) begin
      // A write offered during RESP must be ignored.
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_wr_addr = a; cmd_data = ~ref_mem[a];
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data_a", rsp_data_a, ref_mem[a]);
      chk("bp_data_b", rsp_data_b, ref_mem[b]);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rf_wr", rf_wr, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("rsp_idle_ready", cmd_ready, 1);
    chk("rsp_idle_busy", busy, 0);
    chk("rd_no_writes", wr_pulses - p0, 0);
  endtask

  task automatic do_clear();
    int p0;
    send(2'b11, 3'd0, 3'd0, 3'd0, 16'h0000);
    p0 = wr_pulses;
    for (int i = 0; i < 8; i++) begin
      chk("clr_rf_wr", rf_wr, 1);
      chk("clr_addr", rf_wr_addr, i);
      chk("clr_d_in", rf_d_in, 0);
      chk("clr_busy", busy, 1);
      tick();
    end
    chk("clr_done_rf_wr", rf_wr, 0);
    chk("clr_done_busy", busy, 0);
    chk("clr_pulse_count", wr_pulses - p0, 8);
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
  endtask

  initial begin
    int p0;
    int r;
    for (int i = 0; i < 8; i++) begin rf_mem[i] = '0; ref_mem[i] = '0; end
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr_a = '0; cmd_addr_b = '0;
    cmd_wr_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
    #2 reset = 1'b0;
    #10;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_addr", rf_wr_addr, 0);
    chk("rst_d_in", rf_d_in, 0);
    chk("rst_rd_addr_a", rf_rd_addr_a, 0);
    chk("rst_rsp_data_a", rsp_data_a, 0);
    @(negedge clk) reset = 1'b1;
    tick();

    do_write(3'd3, 16'hcdef);
    do_write(3'd7, 16'h3210);
    do_read(3'd3, 3'd7, 0);
    do_read(3'd5, 3'd0, 3);
    do_clear();
    do_read(3'd3, 3'd7, 0);

    p0 = wr_pulses;
    send(2'b00, 3'd1, 3'd2, 3'd3, 16'hffff);
    chk("nop_busy", busy, 0);
    chk("nop_ready", cmd_ready, 1);
    tick();
    chk("nop_no_writes", wr_pulses - p0, 0);

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5)
        do_write(3'($urandom_range(0, 7)), 16'($urandom));
      else if (r < 9)
        do_read(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
      else
        do_clear();
    end

    // Reset in the middle of CLEAR: registers 4..7 must survive.
    for (int i = 4; i < 7; i++) do_write(3'(i), 16'($urandom) | 16'h0100);
    do_write(3'd7, 16'h3210);
    send(2'b11, 3'd0, 3'd0, 3'd0, 16'h0000);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_addr", rf_wr_addr, 4);
    chk("abort_rf_wr_pre", rf_wr, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_rf_wr", rf_wr, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_wr_addr", rf_wr_addr, 0);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    tick();
    chk("abort_reg7", rf_mem[7], 16'h3210);
    do_read(3'd7, 3'd4, 0);
    do_read(3'd5, 3'd6, 1);
    do_read(3'd0, 3'd3, 0);

`ifdef RFC_READBACK_EN
    do_write(3'd5, 16'h4567);
    chk("vfy_ok_err", err, 0);
    corrupt = 1'b1;
    do_write(3'd5, 16'h4567);
    corrupt = 1'b0;
    chk("vfy_bad_err", err, 1);
    do_write(3'd2, 16'h1111);
    chk("vfy_sticky_err", err, 1);
`else
    corrupt = 1'b1;
    do_write(3'd5, 16'h4567);
    corrupt = 1'b0;
    chk("err_tied_low", err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
